// File: rtl/mem_access_scheduler.sv
// Shared memory port scheduler: VGA read (priority), then round-robin over UART write,
// CPU data and CPU instruction fetch. One registered transaction at a time.
module mem_access_scheduler #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        VGA_state,
    input  logic              VGA_read,
    input  logic [ADDR_W-1:0] VGA_adr,
    output logic              VGA_ack,
    output logic [DATA_W-1:0] data_to_VGA,
    input  logic              UART_write,
    input  logic [ADDR_W-1:0] UART_adr,
    input  logic [DATA_W-1:0] data_from_UART,
    output logic              UART_ack,
    input  logic              CPU_instr_req,
    input  logic [ADDR_W-1:0] CPU_instr_adr,
    input  logic              CPU_read,
    input  logic              CPU_write,
    input  logic [ADDR_W-1:0] CPU_data_adr,
    input  logic [DATA_W-1:0] data_from_CPU,
    input  logic [3:0]        CPU_sel,
    output logic [DATA_W-1:0] instr_data_to_CPU,
    output logic [DATA_W-1:0] data_to_CPU,
    output logic              CPU_enable,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] adr_to_mem,
    output logic [DATA_W-1:0] data_to_mem,
    output logic [3:0]        sel_to_mem,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] data_from_mem
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
    typedef enum logic [1:0] {GntUart = 2'd0, GntData = 2'd1, GntInstr = 2'd2, GntVga = 2'd3} gnt_e;

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              rr_q, rr_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic [DATA_W-1:0] instr_data_q, instr_data_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic              instr_done_q, instr_done_d;
    logic              data_done_q, data_done_d;

    logic       vga_req;
    logic [3:0] req;
    logic       found;
    gnt_e       pick;
    logic [2:0] rr_sum;
    logic [1:0] rr_idx;

    // CPU data waits for its pending fetch; a finished fetch is not re-granted until CPU_enable.
    assign vga_req = VGA_read && (VGA_state == 2'b10);
    assign req[0]  = UART_write;
    assign req[1]  = (CPU_read || CPU_write) && !(CPU_instr_req && !instr_done_q);
    assign req[2]  = CPU_instr_req && !instr_done_q;
    assign req[3]  = 1'b0;

    always_comb begin
        found  = 1'b0;
        pick   = GntUart;
        rr_sum = 3'd0;
        rr_idx = 2'd0;
        for (int unsigned i = 0; i < 3; i++) begin
            rr_sum = {1'b0, rr_q} + 3'(i);
            rr_idx = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
            if (!found && req[rr_idx]) begin
                found = 1'b1;
                pick  = gnt_e'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        adr_d        = adr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        we_d         = we_q;
        vga_data_d   = vga_data_q;
        instr_data_d = instr_data_q;
        cpu_data_d   = cpu_data_q;
        instr_done_d = instr_done_q;
        data_done_d  = data_done_q;
        unique case (state_q)
            StIdle: begin
                if (vga_req) begin
                    gnt_d   = GntVga;
                    adr_d   = VGA_adr;
                    sel_d   = 4'hF;
                    we_d    = 1'b0;
                    state_d = StIssue;
                end else if (found) begin
                    gnt_d   = pick;
                    rr_d    = (pick == GntInstr) ? GntUart : gnt_e'(pick + 2'd1);
                    state_d = StIssue;
                    unique case (pick)
                        GntUart: begin
                            adr_d   = UART_adr;
                            wdata_d = data_from_UART;
                            sel_d   = 4'hF;
                            we_d    = 1'b1;
                        end
                        GntData: begin
                            adr_d   = CPU_data_adr;
                            wdata_d = data_from_CPU;
                            sel_d   = CPU_sel;
                            we_d    = CPU_write;
                        end
                        default: begin
                            adr_d       = CPU_instr_adr;
                            sel_d       = 4'hF;
                            we_d        = 1'b0;
                            data_done_d = !(CPU_read || CPU_write);
                        end
                    endcase
                end
            end
            StIssue: begin
                if (mem_busy) state_d = StWait;
            end
            StWait: begin
                if (!mem_busy) begin
                    state_d = StDone;
                    unique case (gnt_q)
                        GntVga:   vga_data_d   = data_from_mem;
                        GntInstr: instr_data_d = data_from_mem;
                        GntData:  if (!we_q) cpu_data_d = data_from_mem;
                        default:  ;
                    endcase
                end
            end
            default: begin
                state_d = StIdle;
                if (gnt_q == GntInstr) begin
                    instr_done_d = !data_done_q;
                    if (data_done_q) data_done_d = 1'b0;
                end else if (gnt_q == GntData) begin
                    data_done_d = !instr_done_q;
                    if (instr_done_q) instr_done_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            gnt_q        <= GntUart;
            rr_q         <= GntUart;
            adr_q        <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            vga_data_q   <= '0;
            instr_data_q <= '0;
            cpu_data_q   <= '0;
            instr_done_q <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            vga_data_q   <= vga_data_d;
            instr_data_q <= instr_data_d;
            cpu_data_q   <= cpu_data_d;
            instr_done_q <= instr_done_d;
            data_done_q  <= data_done_d;
        end
    end

    // Strobes and acks decode from state so an async reset drops them at once.
    assign mem_read          = (state_q == StIssue) && !we_q;
    assign mem_write         = (state_q == StIssue) && we_q;
    assign adr_to_mem        = adr_q;
    assign data_to_mem       = wdata_q;
    assign sel_to_mem        = sel_q;
    assign VGA_ack           = (state_q == StDone) && (gnt_q == GntVga);
    assign UART_ack          = (state_q == StDone) && (gnt_q == GntUart);
    assign CPU_enable        = (state_q == StDone) &&
                               (((gnt_q == GntInstr) && data_done_q) ||
                                ((gnt_q == GntData) && instr_done_q));
    assign data_to_VGA       = vga_data_q;
    assign instr_data_to_CPU = instr_data_q;
    assign data_to_CPU       = cpu_data_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Directed bench for mem_access_scheduler with a zero-wait memory model and grant log.
module tb_mem_access_scheduler;

    logic        clk, rst;
    logic [1:0]  VGA_state;
    logic        VGA_read, VGA_ack;
    logic [31:0] VGA_adr, data_to_VGA;
    logic        UART_write, UART_ack;
    logic [31:0] UART_adr, data_from_UART;
    logic        CPU_instr_req, CPU_read, CPU_write, CPU_enable;
    logic [31:0] CPU_instr_adr, CPU_data_adr, data_from_CPU, instr_data_to_CPU, data_to_CPU;
    logic [3:0]  CPU_sel, sel_to_mem;
    logic        mem_read, mem_write, mem_busy;
    logic [31:0] adr_to_mem, data_to_mem, data_from_mem;

    logic        mem_en;
    bit          auto_drop;
    int          checks, errors;
    int          vga_cnt, uart_cnt, en_cnt;
    int          b_vga, b_uart, b_en, lat;
    logic [31:0] log_q[$];
    logic [31:0] exp5[6];

    mem_access_scheduler #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .VGA_state(VGA_state), .VGA_read(VGA_read), .VGA_adr(VGA_adr),
        .VGA_ack(VGA_ack), .data_to_VGA(data_to_VGA),
        .UART_write(UART_write), .UART_adr(UART_adr), .data_from_UART(data_from_UART),
        .UART_ack(UART_ack),
        .CPU_instr_req(CPU_instr_req), .CPU_instr_adr(CPU_instr_adr),
        .CPU_read(CPU_read), .CPU_write(CPU_write), .CPU_data_adr(CPU_data_adr),
        .data_from_CPU(data_from_CPU), .CPU_sel(CPU_sel),
        .instr_data_to_CPU(instr_data_to_CPU), .data_to_CPU(data_to_CPU),
        .CPU_enable(CPU_enable),
        .mem_read(mem_read), .mem_write(mem_write), .adr_to_mem(adr_to_mem),
        .data_to_mem(data_to_mem), .sel_to_mem(sel_to_mem),
        .mem_busy(mem_busy), .data_from_mem(data_from_mem)
    );

    // Memory answers busy while strobed and drops it the next cycle.
    assign mem_busy      = mem_en & (mem_read | mem_write);
    assign data_from_mem = (adr_to_mem == 32'h100) ? 32'hDEADBEEF : (adr_to_mem ^ 32'h5A5A5A5A);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (VGA_ack)    vga_cnt  <= vga_cnt + 1;
        if (UART_ack)   uart_cnt <= uart_cnt + 1;
        if (CPU_enable) en_cnt   <= en_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if ((mem_read || mem_write) && mem_busy) begin
            log_q.push_back(adr_to_mem);
            if (auto_drop && adr_to_mem == CPU_data_adr) begin
                CPU_read  = 1'b0;
                CPU_write = 1'b0;
            end
        end
        if (auto_drop) begin
            if (VGA_ack) VGA_read = 1'b0;
            if (UART_ack) UART_write = 1'b0;
            if (CPU_enable) begin
                CPU_instr_req = 1'b0;
                CPU_read      = 1'b0;
                CPU_write     = 1'b0;
            end
        end
    endtask

    task automatic run_until(input int want, input int max_cyc);
        for (int n = 0; n < max_cyc && log_q.size() < want; n++) step();
        check("grant_timeout", log_q.size(), want);
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        checks = 0; errors = 0; vga_cnt = 0; uart_cnt = 0; en_cnt = 0;
        rst = 1'b1; mem_en = 1'b1; auto_drop = 1'b1;
        VGA_state = 2'b00; VGA_read = 1'b0; VGA_adr = '0;
        UART_write = 1'b0; UART_adr = '0; data_from_UART = '0;
        CPU_instr_req = 1'b0; CPU_instr_adr = '0; CPU_read = 1'b0; CPU_write = 1'b0;
        CPU_data_adr = '0; data_from_CPU = '0; CPU_sel = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_adr", adr_to_mem, 0);
        check("rst_sel", 32'(sel_to_mem), 0);
        check("rst_cpu_en", 32'(CPU_enable), 0);
        check("rst_data_cpu", data_to_CPU, 0);
        rst = 1'b0;

        // Reset while a write sits in ISSUE
        mem_en = 1'b0;
        UART_write = 1'b1; UART_adr = 32'h40; data_from_UART = 32'h11;
        @(negedge clk);
        check("t1_issue_write", 32'(mem_write), 1);
        rst = 1'b1;
        #1;
        check("t1_write_dropped", 32'(mem_write), 0);
        check("t1_adr_cleared", adr_to_mem, 0);
        @(negedge clk);
        rst = 1'b0; UART_write = 1'b0; mem_en = 1'b1;
        run_cycles(4);
        check("t1_no_ack", 32'(uart_cnt + vga_cnt + en_cnt), 0);
        check("t1_no_grant", log_q.size(), 0);

        // Fetch only; request sampled in IDLE, enable in DONE (4th cycle)
        CPU_instr_req = 1'b1; CPU_instr_adr = 32'h100;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 1) begin
                check("t2_read", 32'(mem_read), 1);
                check("t2_adr", adr_to_mem, 32'h100);
                check("t2_sel", 32'(sel_to_mem), 32'hF);
            end
            if (CPU_enable) begin
                lat = n;
                break;
            end
        end
        check("t2_en_latency", lat, 3);
        check("t2_instr", instr_data_to_CPU, 32'hDEADBEEF);
        run_cycles(4);
        check("t2_en_once", en_cnt, 1);

        // Round-robin with UART and CPU data held continuously
        log_q.delete();
        auto_drop = 1'b0;
        b_uart = uart_cnt;
        UART_write = 1'b1; UART_adr = 32'h48; data_from_UART = 32'h66;
        CPU_write = 1'b1; CPU_data_adr = 32'h320; data_from_CPU = 32'h77; CPU_sel = 4'hF;
        run_until(6, 60);
        UART_write = 1'b0; CPU_write = 1'b0;
        exp5 = '{32'h48, 32'h320, 32'h48, 32'h320, 32'h48, 32'h320};
        for (int i = 0; i < 6; i++) check($sformatf("t5_grant%0d", i), log_q[i], exp5[i]);
        run_cycles(6);
        check("t5_total_grants", log_q.size(), 6);
        check("t5_uart_acks", uart_cnt - b_uart, 3);
        auto_drop = 1'b1;

        // VGA ACTIVE beats UART and CPU data
        log_q.delete();
        b_vga = vga_cnt; b_uart = uart_cnt;
        VGA_state = 2'b10; VGA_read = 1'b1; VGA_adr = 32'h2000;
        UART_write = 1'b1; UART_adr = 32'h44; data_from_UART = 32'h22;
        CPU_read = 1'b1; CPU_data_adr = 32'h300; CPU_sel = 4'hF;
        run_until(3, 40);
        run_cycles(4);
        check("t3_first_vga", log_q[0], 32'h2000);
        check("t3_second_uart", log_q[1], 32'h44);
        check("t3_third_data", log_q[2], 32'h300);
        check("t3_total", log_q.size(), 3);
        check("t3_vga_data", data_to_VGA, 32'h5A5A7A5A);
        check("t3_cpu_data", data_to_CPU, 32'h5A5A595A);
        check("t3_vga_acks", vga_cnt - b_vga, 1);
        check("t3_uart_acks", uart_cnt - b_uart, 1);

        // VGA READY is ignored; UART write goes through
        log_q.delete();
        b_vga = vga_cnt; b_uart = uart_cnt;
        VGA_state = 2'b01; VGA_read = 1'b1; VGA_adr = 32'h2100;
        UART_write = 1'b1; UART_adr = 32'h40; data_from_UART = 32'h55;
        run_until(1, 20);
        check("t4_write", 32'(mem_write), 1);
        check("t4_adr", adr_to_mem, 32'h40);
        check("t4_data", data_to_mem, 32'h55);
        run_cycles(10);
        check("t4_only_uart", log_q.size(), 1);
        check("t4_uart_ack_once", uart_cnt - b_uart, 1);
        check("t4_no_vga_ack", vga_cnt - b_vga, 0);
        VGA_read = 1'b0; VGA_state = 2'b00;

        // Fetch plus byte-lane write; enable only after both
        log_q.delete();
        b_en = en_cnt;
        CPU_instr_req = 1'b1; CPU_instr_adr = 32'h180;
        CPU_write = 1'b1; CPU_data_adr = 32'h340; data_from_CPU = 32'hCAFE0011; CPU_sel = 4'b0011;
        run_until(1, 20);
        check("t6_fetch_adr", adr_to_mem, 32'h180);
        check("t6_fetch_read", 32'(mem_read), 1);
        run_until(2, 20);
        check("t6_write", 32'(mem_write), 1);
        check("t6_wr_adr", adr_to_mem, 32'h340);
        check("t6_wr_sel", 32'(sel_to_mem), 32'h3);
        check("t6_wr_data", data_to_mem, 32'hCAFE0011);
        check("t6_no_early_en", en_cnt - b_en, 0);
        run_cycles(5);
        check("t6_en_once", en_cnt - b_en, 1);
        check("t6_total", log_q.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
